// File: rtl/ecc_scalar_mult.sv
// Double-and-add scalar multiplier kP over GF(p) with start/busy/done handshake.
// The adder and doubler run side by side on every scalar bit; O is reported as an explicit flag.

module point_addition #(
  parameter int n = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         infinity,
  output logic         result
);
  localparam int IW = $clog2(n);

  typedef enum logic [3:0] {
    ST_PREP, ST_MUL, ST_NUM, ST_EXP, ST_EXP_SQ, ST_EXP_ML, ST_EXP_NEXT,
    ST_LAM, ST_X3, ST_Y3, ST_DONE
  } pa_state_t;

  pa_state_t      state_r, ret_r;
  logic [n-1:0]   num_r, den_r, inv_r, lam_r, m_a_r, m_b_r, m_acc_r;
  logic [IW-1:0]  m_i_r, e_i_r;
  logic [n-1:0]   exp_s, x3_s;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] u, v, m);
    logic [n:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    else                s = s;
    mod_add = s[n-1:0];
  endfunction

  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] u, v, m);
    logic [n:0] s;
    s = {1'b0, u} + {1'b0, m} - {1'b0, v};
    if (u >= v) mod_sub = u - v;
    else        mod_sub = s[n-1:0];
  endfunction

  // One MSB-first step of interleaved modular multiplication.
  function automatic logic [n-1:0] mul_step(input logic [n-1:0] acc, u, input logic b,
                                            input logic [n-1:0] m);
    logic [n-1:0] dbl_v;
    dbl_v = mod_add(acc, acc, m);
    if (b) mul_step = mod_add(dbl_v, u, m);
    else   mul_step = dbl_v;
  endfunction

  // Inversion by Fermat (p prime): den^(p-2).
  assign exp_s = p - n'(2);
  assign x3_s  = mod_sub(mod_sub(m_acc_r, x1, p), x2, p);

  // Micro-sequencer: case split, inverse, then lambda, x3, y3 through one shared multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_PREP;
      ret_r    <= ST_DONE;
      num_r    <= '0;
      den_r    <= '0;
      inv_r    <= '0;
      lam_r    <= '0;
      m_a_r    <= '0;
      m_b_r    <= '0;
      m_acc_r  <= '0;
      m_i_r    <= '0;
      e_i_r    <= '0;
      x3       <= '0;
      y3       <= '0;
      infinity <= 1'b0;
      result   <= 1'b0;
    end else begin
      case (state_r)
        ST_PREP: begin
          if (x1 == x2 && mod_add(y1, y2, p) == '0) begin
            x3       <= '0;
            y3       <= '0;
            infinity <= 1'b1;
            result   <= 1'b1;
            state_r  <= ST_DONE;
          end else if (x1 == x2) begin
            den_r   <= mod_add(y1, y1, p);
            m_a_r   <= x1;
            m_b_r   <= x1;
            m_acc_r <= '0;
            m_i_r   <= IW'(n - 1);
            ret_r   <= ST_NUM;
            state_r <= ST_MUL;
          end else begin
            num_r   <= mod_sub(y2, y1, p);
            den_r   <= mod_sub(x2, x1, p);
            inv_r   <= n'(1);
            e_i_r   <= IW'(n - 1);
            state_r <= ST_EXP;
          end
        end
        ST_MUL: begin
          m_acc_r <= mul_step(m_acc_r, m_a_r, m_b_r[m_i_r], p);
          if (m_i_r == '0) state_r <= ret_r;
          else             m_i_r   <= m_i_r - IW'(1);
        end
        ST_NUM: begin
          num_r   <= mod_add(mod_add(mod_add(m_acc_r, m_acc_r, p), m_acc_r, p), a, p);
          inv_r   <= n'(1);
          e_i_r   <= IW'(n - 1);
          state_r <= ST_EXP;
        end
        ST_EXP: begin
          m_a_r   <= inv_r;
          m_b_r   <= inv_r;
          m_acc_r <= '0;
          m_i_r   <= IW'(n - 1);
          ret_r   <= ST_EXP_SQ;
          state_r <= ST_MUL;
        end
        ST_EXP_SQ: begin
          inv_r <= m_acc_r;
          if (exp_s[e_i_r]) begin
            m_a_r   <= m_acc_r;
            m_b_r   <= den_r;
            m_acc_r <= '0;
            m_i_r   <= IW'(n - 1);
            ret_r   <= ST_EXP_ML;
            state_r <= ST_MUL;
          end else begin
            state_r <= ST_EXP_NEXT;
          end
        end
        ST_EXP_ML: begin
          inv_r   <= m_acc_r;
          state_r <= ST_EXP_NEXT;
        end
        ST_EXP_NEXT: begin
          if (e_i_r == '0) begin
            m_a_r   <= num_r;
            m_b_r   <= inv_r;
            m_acc_r <= '0;
            m_i_r   <= IW'(n - 1);
            ret_r   <= ST_LAM;
            state_r <= ST_MUL;
          end else begin
            e_i_r   <= e_i_r - IW'(1);
            state_r <= ST_EXP;
          end
        end
        ST_LAM: begin
          lam_r   <= m_acc_r;
          m_a_r   <= m_acc_r;
          m_b_r   <= m_acc_r;
          m_acc_r <= '0;
          m_i_r   <= IW'(n - 1);
          ret_r   <= ST_X3;
          state_r <= ST_MUL;
        end
        ST_X3: begin
          x3      <= x3_s;
          m_a_r   <= lam_r;
          m_b_r   <= mod_sub(x1, x3_s, p);
          m_acc_r <= '0;
          m_i_r   <= IW'(n - 1);
          ret_r   <= ST_Y3;
          state_r <= ST_MUL;
        end
        ST_Y3: begin
          y3       <= mod_sub(m_acc_r, y1, p);
          infinity <= 1'b0;
          result   <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: state_r <= ST_DONE;
        default: state_r <= ST_DONE;
      endcase
    end
  end
endmodule

module point_doubling #(
  parameter int n = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         infinity,
  output logic         result
);
  // The adder's tangent branch is exactly the doubling formula.
  point_addition #(.n(n)) u_core (
    .clk(clk), .reset(reset), .p(p), .a(a),
    .x1(x1), .y1(y1), .x2(x1), .y2(y1),
    .x3(x3), .y3(y3), .infinity(infinity), .result(result)
  );
endmodule

module ecc_scalar_mult #(
  parameter int n     = 231,
  parameter int KBITS = 231,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [n-1:0]     p,
  input  logic [n-1:0]     a,
  input  logic [KBITS-1:0] k,
  input  logic [n-1:0]     x1,
  input  logic [n-1:0]     y1,
  output logic             busy,
  output logic             done,
  output logic [n-1:0]     x3,
  output logic [n-1:0]     y3,
  output logic             infinity
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, UPDATE, FINISH} state_t;

  state_t           state_r;
  logic             mode_r;
  logic [n-1:0]     p_r, a_r, rx_r, ry_r, qx_r, qy_r, ax_r, ay_r, dx_r, dy_r;
  logic             rinf_r, qinf_r, ainf_r, dinf_r;
  logic [KBITS-1:0] ks_r;
  logic [CW-1:0]    cnt_r;
  logic             add_rst_r, dbl_rst_r, add_go_r, dbl_go_r, add_done_r, dbl_done_r;
  logic [n-1:0]     add_x3_s, add_y3_s, dbl_x3_s, dbl_y3_s;
  logic             add_inf_s, add_res_s, dbl_inf_s, dbl_res_s, add_go_s, dbl_go_s;

  // Early-terminate mode skips units whose result cannot reach R or a later Q.
  assign add_go_s = mode_r | (ks_r[0] & ~rinf_r & ~qinf_r);
  assign dbl_go_s = mode_r | (~qinf_r & (ks_r[KBITS-1:1] != '0));

  point_addition #(.n(n)) u_add (
    .clk(clk), .reset(add_rst_r), .p(p_r), .a(a_r),
    .x1(rx_r), .y1(ry_r), .x2(qx_r), .y2(qy_r),
    .x3(add_x3_s), .y3(add_y3_s), .infinity(add_inf_s), .result(add_res_s)
  );

  point_doubling #(.n(n)) u_dbl (
    .clk(clk), .reset(dbl_rst_r), .p(p_r), .a(a_r),
    .x1(qx_r), .y1(qy_r),
    .x3(dbl_x3_s), .y3(dbl_y3_s), .infinity(dbl_inf_s), .result(dbl_res_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      mode_r     <= 1'b0;
      p_r        <= '0;
      a_r        <= '0;
      rx_r       <= '0;
      ry_r       <= '0;
      rinf_r     <= 1'b0;
      qx_r       <= '0;
      qy_r       <= '0;
      qinf_r     <= 1'b0;
      ax_r       <= '0;
      ay_r       <= '0;
      ainf_r     <= 1'b0;
      dx_r       <= '0;
      dy_r       <= '0;
      dinf_r     <= 1'b0;
      ks_r       <= '0;
      cnt_r      <= '0;
      add_rst_r  <= 1'b1;
      dbl_rst_r  <= 1'b1;
      add_go_r   <= 1'b0;
      dbl_go_r   <= 1'b0;
      add_done_r <= 1'b0;
      dbl_done_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x3         <= '0;
      y3         <= '0;
      infinity   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            p_r     <= p;
            a_r     <= a;
            ks_r    <= k;
            mode_r  <= mode;
            rx_r    <= '0;
            ry_r    <= '0;
            rinf_r  <= 1'b1;
            qx_r    <= x1;
            qy_r    <= y1;
            qinf_r  <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= CHECK;
          end else begin
            state_r <= IDLE;
          end
        end
        CHECK: begin
          if ((!mode_r && ks_r == '0) || (mode_r && cnt_r == CW'(KBITS))) state_r <= FINISH;
          else                                                          state_r <= ISSUE;
        end
        ISSUE: begin
          add_rst_r  <= ~add_go_s;
          dbl_rst_r  <= ~dbl_go_s;
          add_go_r   <= add_go_s;
          dbl_go_r   <= dbl_go_s;
          add_done_r <= ~add_go_s;
          dbl_done_r <= ~dbl_go_s;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (add_res_s && !add_done_r && !add_rst_r) begin
            ax_r       <= add_x3_s;
            ay_r       <= add_y3_s;
            ainf_r     <= add_inf_s;
            add_done_r <= 1'b1;
            add_rst_r  <= 1'b1;
          end else begin
            add_done_r <= add_done_r;
          end
          if (dbl_res_s && !dbl_done_r && !dbl_rst_r) begin
            dx_r       <= dbl_x3_s;
            dy_r       <= dbl_y3_s;
            dinf_r     <= dbl_inf_s;
            dbl_done_r <= 1'b1;
            dbl_rst_r  <= 1'b1;
          end else begin
            dbl_done_r <= dbl_done_r;
          end
          if (add_done_r && dbl_done_r) state_r <= UPDATE;
          else                          state_r <= WAIT;
        end
        UPDATE: begin
          if (ks_r[0] && rinf_r) begin
            rx_r   <= qx_r;
            ry_r   <= qy_r;
            rinf_r <= qinf_r;
          end else if (ks_r[0] && !qinf_r && add_go_r) begin
            rx_r   <= ax_r;
            ry_r   <= ay_r;
            rinf_r <= ainf_r;
          end else begin
            rinf_r <= rinf_r;
          end
          if (!qinf_r && dbl_go_r) begin
            qx_r   <= dx_r;
            qy_r   <= dy_r;
            qinf_r <= dinf_r;
          end else begin
            qinf_r <= qinf_r;
          end
          ks_r    <= ks_r >> 1;
          cnt_r   <= cnt_r + CW'(1);
          state_r <= CHECK;
        end
        FINISH: begin
          x3       <= rinf_r ? '0 : rx_r;
          y3       <= rinf_r ? '0 : ry_r;
          infinity <= rinf_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scalar_mult.sv
// Directed and random checks of ecc_scalar_mult on y^2 = x^3 + 2x + 2 mod 17, P = (5, 1).
module tb_ecc_scalar_mult;
  localparam int N = 8, KB = 8, CWID = 4, PP = 17, AA = 2;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic [N-1:0] p = 8'd17, a = 8'd2, x1 = 8'd5, y1 = 8'd1;
  logic [KB-1:0] k = 8'd0;
  logic busy, done, infinity;
  logic [N-1:0] x3, y3;

  int tests = 0, failed = 0;
  int mx[0:31], my[0:31];
  bit minf[0:31];
  int ord = 0;

  ecc_scalar_mult #(.n(N), .KBITS(KB), .CW(CWID)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .p(p), .a(a), .k(k),
    .x1(x1), .y1(y1), .busy(busy), .done(done), .x3(x3), .y3(y3), .infinity(infinity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int minv(input int d);
    for (int i = 1; i < PP; i++) if ((d * i) % PP == 1) return i;
    return 0;
  endfunction

  // Textbook affine group law with plain integers.
  task automatic model_add(input int ax, ay, input bit ai, input int bx, by, input bit bi,
                           output int rx, ry, output bit ri);
    int lam;
    rx = 0; ry = 0; ri = 1'b0;
    if (ai) begin rx = bx; ry = by; ri = bi; end
    else if (bi) begin rx = ax; ry = ay; ri = ai; end
    else if (ax == bx && (ay + by) % PP == 0) ri = 1'b1;
    else begin
      if (ax == bx) lam = ((3 * ax * ax + AA) % PP) * minv((2 * ay) % PP) % PP;
      else          lam = ((by - ay + PP) % PP) * minv((bx - ax + PP) % PP) % PP;
      rx = (lam * lam - ax - bx + 2 * PP) % PP;
      ry = (lam * ((ax - rx + PP) % PP) - ay + PP * PP) % PP;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one multiplication; start is re-pulsed with junk operands at cycle pulse_at.
  task automatic run(input logic [7:0] kk, input logic md, input int pulse_at,
                     output int cyc, output int busy_bad, output int dbl_starts, output int iters);
    logic prev;
    k = kk; mode = md; x1 = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; cyc = 1; busy_bad = 0; dbl_starts = 0; prev = dut.dbl_rst_r;
    while (!done && cyc < 4000) begin
      if (!busy) busy_bad++;
      start = (cyc == pulse_at);
      k  = start ? 8'd7 : kk;
      x1 = start ? 8'd0 : 8'd5;
      tick();
      cyc++;
      if (prev && !dut.dbl_rst_r) dbl_starts++;
      prev = dut.dbl_rst_r;
    end
    start = 1'b0; k = kk; x1 = 8'd5;
    iters = int'(dut.cnt_r);
  endtask

  task automatic run_check(input string tag, input logic [7:0] kk, input logic md, input int pulse_at,
                           output int cyc, output int dbl_starts, output int iters);
    int busy_bad, r;
    run(kk, md, pulse_at, cyc, busy_bad, dbl_starts, iters);
    r = int'(kk) % ord;
    check({tag, ".done"}, done, 1);
    check({tag, ".x3"}, x3, minf[r] ? 0 : mx[r]);
    check({tag, ".y3"}, y3, minf[r] ? 0 : my[r]);
    check({tag, ".inf"}, infinity, minf[r]);
    check({tag, ".busy_hi"}, busy_bad, 0);
    check({tag, ".busy_lo"}, busy, 0);
    tick();
    check({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    int cyc, ds, it, dc;
    logic md;
    minf[0] = 1'b1; mx[0] = 0; my[0] = 0;
    mx[1] = 5; my[1] = 1; minf[1] = 1'b0;
    for (int m = 2; m < 32 && ord == 0; m++) begin
      model_add(mx[m-1], my[m-1], minf[m-1], 5, 1, 1'b0, mx[m], my[m], minf[m]);
      if (minf[m]) ord = m;
    end
    check("model.order", ord, 19);

    repeat (3) tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.x3", x3, 0);
    check("rst.y3", y3, 0);
    check("rst.inf", infinity, 0);
    reset = 1'b1;
    tick();

    run_check("k1", 8'd1, 1'b0, -1, cyc, ds, it);
    check("k1.const", {x3, y3}, {8'd5, 8'd1});
    check("k1.iters", it, 1);
    run_check("k2", 8'd2, 1'b0, -1, cyc, ds, it);
    check("k2.const", {x3, y3}, {8'd6, 8'd3});
    run_check("k3", 8'd3, 1'b0, -1, cyc, ds, it);
    check("k3.const", {x3, y3}, {8'd10, 8'd6});
    run_check("k5", 8'd5, 1'b0, -1, cyc, ds, it);
    check("k5.const", {x3, y3}, {8'd9, 8'd16});
    run_check("k19", 8'd19, 1'b0, -1, cyc, ds, it);
    check("k19.const", {infinity, x3, y3}, {1'b1, 8'd0, 8'd0});
    run_check("k18", 8'd18, 1'b0, -1, cyc, ds, it);
    check("k18.const", {x3, y3}, {8'd5, 8'd16});
    run_check("k0m0", 8'd0, 1'b0, -1, cyc, ds, it);
    check("k0m0.latency", cyc, 3);
    check("k0m0.inf", infinity, 1);
    run_check("k0m1", 8'd0, 1'b1, -1, cyc, ds, it);
    check("k0m1.iters", it, 8);
    run_check("k5m1", 8'd5, 1'b1, -1, cyc, ds, it);
    check("k5m1.const", {x3, y3}, {8'd9, 8'd16});
    check("k5m1.issues", ds, 8);
    check("k5m1.iters", it, 8);

    // Abort a k = 18 run while the units are busy.
    k = 8'd18; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("abort.busy_before", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.out", {infinity, x3, y3}, 17'd0);
    dc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) dc++;
    end
    check("abort.no_done", dc, 0);

    run_check("k3_ignore", 8'd3, 1'b0, 10, cyc, ds, it);
    check("k3_ignore.const", {x3, y3}, {8'd10, 8'd6});

    for (int i = 0; i < 12; i++) begin
      md = (i % 4 == 3);
      run_check($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)), md, -1, cyc, ds, it);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ecc_scalar_mult.md
Name: ecc_scalar_mult

Overview:
- Parametrised successor to the double-and-add scalar multiplier: computes kP over GF(p), returning the point at infinity (O) as an explicit flag.
- Uses the existing point_addition and point_doubling units, one instance of each, and runs them in parallel on every scalar bit.
- Adds a start/busy/done handshake, a scalar width decoupled from field width, and a constant-iteration mode.
- Sits between the protocol controller and the field-arithmetic units.

Parameters:
- n, 231: field element width (p, a, coordinates).
- KBITS, 231: scalar width.
- CW, 8: width of the iteration counter; must satisfy 2^CW > KBITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- start  in  1  request; accepted only in IDLE.
- mode  in  1  0 = early-terminate, 1 = constant-iteration (dummy adds, always KBITS iterations).
- p  in  n  field modulus.
- a  in  n  curve coefficient.
- k  in  KBITS  scalar.
- x1  in  n  base point x coordinate.
- y1  in  n  base point y coordinate.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; results are valid in that cycle.
- x3  out  n  result x coordinate; held until the next accepted start.
- y3  out  n  result y coordinate; held until the next accepted start.
- infinity  out  1  result is O; x3 = y3 = 0 when set.

Behaviour:
- Reset (reset == 0): FSM to IDLE; busy = 0, done = 0, x3 = 0, y3 = 0, infinity = 0; both sub-unit resets held high; internal registers cleared.
- Sub-unit handshake: drive operands, hold the sub-unit reset high for exactly 1 cycle with operands stable, then low. Wait for result == 1, then capture x3, y3 and infinity from the unit. Operands must not change while the unit is running.
- Internal state:
  - R (accumulator): x, y, inf; initialised to O.
  - Q (running double): x, y, inf; initialised to (x1, y1, 0).
  - ks: shift copy of k.
  - cnt: CW-bit iteration counter.
- States:
  - IDLE: on start, latch p, a, k, x1, y1, mode; R = O; Q = P; cnt = 0; go to CHECK. busy rises the next cycle.
  - CHECK:
    - mode 0 and ks == 0 -> FINISH.
    - mode 1 and cnt == KBITS -> FINISH.
    - otherwise -> ISSUE.
  - ISSUE: assert both sub-unit resets for 1 cycle. Adder inputs are R, Q; doubler input is Q. -> WAIT.
  - WAIT:
    - Register each unit's result when its result flag first goes high.
    - Leave only when both units are done, or when a unit that was bypassed is marked done.
    - -> UPDATE.
  - UPDATE: bit = ks[0].
    - bit = 1, R.inf = 1: R <= Q.
    - bit = 1, Q.inf = 1: R unchanged.
    - bit = 1, otherwise: R <= adder result, including its infinity flag (covers P + (-P)).
    - bit = 0: adder result discarded. In mode 0 the adder is never started when bit = 0; its done is forced.
    - Q.inf = 1: Q stays O and the doubler is not started.
    - Otherwise Q <= doubler result.
    - Then ks >>= 1; cnt += 1; -> CHECK.
  - FINISH: x3/y3 <= R (zeros if R.inf); infinity <= R.inf; done = 1 for one cycle; busy <= 0; -> IDLE.
- Mode 0 may skip the doubler when ks[KBITS-1:1] == 0 (its result would be unused).
- Mode 1 always starts both units in every iteration, regardless of bit value or infinity flags. Discarded results never reach R.
- start while busy is ignored. Inputs are sampled only at acceptance.
- k == 0:
  - mode 0: done exactly 3 cycles after start (IDLE -> CHECK -> FINISH), infinity = 1.
  - mode 1: full KBITS iterations, then infinity = 1.
- Reset asserted mid-operation: abort within the same edge, no done pulse, outputs cleared.
- start and reset low in the same cycle: reset wins.

Test Plan:
- Shared setup: n = 8, KBITS = 8, curve y^2 = x^3 + 2x + 2 mod 17 (p = 17, a = 2), P = (5, 1).
- k = 1, mode 0 -> x3 = 5, y3 = 1, infinity = 0; exactly one add-path iteration; single done pulse.
- k = 2, mode 0 -> (6, 3); k = 3 -> (10, 6); k = 5 -> (9, 16); busy stays high throughout each run.
- k = 19, mode 0 (3G + 16G = O) -> infinity = 1, x3 = y3 = 0; k = 18 -> (5, 16).
- k = 5, mode 1 -> (9, 16) and exactly 8 iterations (count ISSUE states). k = 0, mode 0 -> infinity = 1 with done 3 cycles after start.
- reset low during WAIT of a k = 18 run -> no done pulse; busy = 0, outputs zero next cycle. Then start k = 3 -> (10, 6). A start pulse while busy -> ignored, first result unchanged.
